// File: rtl/tty_writer_if.sv
// Character stream handshake plus character-RAM port B for tty_writer.
// master = character source / RAM side, slave = the writer.
interface tty_writer_if;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic [12:0] addrb;
  logic [7:0]  dinb;
  logic        web;
  logic        enb;
  logic [7:0]  doutb;

  modport master (
    output char_valid, char_data, doutb,
    input  char_ready, addrb, dinb, web, enb
  );
  modport slave (
    input  char_valid, char_data, doutb,
    output char_ready, addrb, dinb, web, enb
  );
endinterface

// File: rtl/tty_writer.sv
// Text-terminal writer: turns a byte stream into character-RAM writes with cursor,
// newline, scroll and form-feed clear. Define TTY_TAB_EN to expand 0x09 into spaces.
module tty_writer #(
  parameter int COLS = 64,
  parameter int ROWS = 32
) (
  input  logic        clk_data,
  input  logic        irst_n,
  tty_writer_if.slave bus,
  output logic        busy
);
  localparam logic [6:0] CMAX = 7'(COLS - 1);
  localparam logic [5:0] RMAX = 6'(ROWS - 1);
  localparam logic [5:0] RPEN = 6'(ROWS - 2);
  localparam logic [7:0] SP   = 8'h20;

  typedef enum logic [2:0] {
    IDLE, PUT, ADV, SCROLL_RD, SCROLL_WR, CLEAR_ROW, CLEAR_ALL
  } state_t;

  state_t      state;
  logic [5:0]  row, sr;
  logic [6:0]  col, sc;
  logic [12:0] addr_q;
  logic [7:0]  din_q;
  logic        we_q, en_q, rdy_q;
  logic        printable;
`ifdef TTY_TAB_EN
  logic        tab;
`endif

  assign printable      = (bus.char_data >= 8'h20) && (bus.char_data <= 8'h7E);
  assign bus.char_ready = rdy_q;
  assign bus.addrb      = addr_q;
  assign bus.web        = we_q;
  assign bus.enb        = en_q;
  // scroll data only arrives from the RAM during the write cycle itself
  assign bus.dinb       = (state == SCROLL_WR) ? bus.doutb : din_q;

  // Each transition also loads the RAM strobes for the state being entered,
  // so a state's access is on the bus for exactly the cycles it occupies.
  always_ff @(posedge clk_data) begin
    if (!irst_n) begin
      state  <= CLEAR_ALL;
      row    <= '0;
      col    <= '0;
      sr     <= '0;
      sc     <= '0;
      addr_q <= '0;
      din_q  <= SP;
      we_q   <= 1'b0;
      en_q   <= 1'b0;
      rdy_q  <= 1'b0;
      busy   <= 1'b1;
`ifdef TTY_TAB_EN
      tab    <= 1'b0;
`endif
    end else begin
      we_q  <= 1'b0;
      en_q  <= 1'b0;
      rdy_q <= 1'b0;
      busy  <= 1'b1;
      case (state)
        IDLE: begin
          rdy_q <= 1'b1;
          busy  <= 1'b0;
          if (bus.char_valid) begin
            if (printable) begin
              state  <= PUT;
              we_q   <= 1'b1;
              en_q   <= 1'b1;
              addr_q <= {row, col};
              din_q  <= bus.char_data;
              rdy_q  <= 1'b0;
              busy   <= 1'b1;
`ifdef TTY_TAB_EN
              tab    <= 1'b0;
`endif
            end else if (bus.char_data == 8'h0A) begin
              if (row == RMAX) begin
                state  <= SCROLL_RD;
                en_q   <= 1'b1;
                addr_q <= {6'd1, 7'd0};
                sr     <= '0;
                sc     <= '0;
                rdy_q  <= 1'b0;
                busy   <= 1'b1;
              end else begin
                row <= row + 6'd1;
              end
            end else if (bus.char_data == 8'h0D) begin
              col <= '0;
            end else if (bus.char_data == 8'h08) begin
              if (col != '0) col <= col - 7'd1;
            end else if (bus.char_data == 8'h0C) begin
              state  <= CLEAR_ALL;
              we_q   <= 1'b1;
              en_q   <= 1'b1;
              addr_q <= '0;
              din_q  <= SP;
              sr     <= '0;
              sc     <= '0;
              rdy_q  <= 1'b0;
              busy   <= 1'b1;
`ifdef TTY_TAB_EN
            end else if (bus.char_data == 8'h09) begin
              state  <= PUT;
              we_q   <= 1'b1;
              en_q   <= 1'b1;
              addr_q <= {row, col};
              din_q  <= SP;
              tab    <= 1'b1;
              rdy_q  <= 1'b0;
              busy   <= 1'b1;
`endif
            end
          end
        end
        PUT: state <= ADV;
        ADV: begin
          if (col == CMAX) begin
            col <= '0;
            if (row == RMAX) begin
              state  <= SCROLL_RD;
              en_q   <= 1'b1;
              addr_q <= {6'd1, 7'd0};
              sr     <= '0;
              sc     <= '0;
            end else begin
              row   <= row + 6'd1;
              state <= IDLE;
              rdy_q <= 1'b1;
              busy  <= 1'b0;
            end
`ifdef TTY_TAB_EN
          end else if (tab && (col[2:0] != 3'd7)) begin
            col    <= col + 7'd1;
            state  <= PUT;
            we_q   <= 1'b1;
            en_q   <= 1'b1;
            addr_q <= {row, col + 7'd1};
`endif
          end else begin
            col   <= col + 7'd1;
            state <= IDLE;
            rdy_q <= 1'b1;
            busy  <= 1'b0;
          end
        end
        SCROLL_RD: begin
          state  <= SCROLL_WR;
          we_q   <= 1'b1;
          en_q   <= 1'b1;
          addr_q <= {sr, sc};
        end
        SCROLL_WR: begin
          if (sc == CMAX) begin
            sc <= '0;
            if (sr == RPEN) begin
              state  <= CLEAR_ROW;
              we_q   <= 1'b1;
              en_q   <= 1'b1;
              addr_q <= {RMAX, 7'd0};
              din_q  <= SP;
            end else begin
              sr     <= sr + 6'd1;
              state  <= SCROLL_RD;
              en_q   <= 1'b1;
              addr_q <= {sr + 6'd2, 7'd0};
            end
          end else begin
            sc     <= sc + 7'd1;
            state  <= SCROLL_RD;
            en_q   <= 1'b1;
            addr_q <= {sr + 6'd1, sc + 7'd1};
          end
        end
        CLEAR_ROW: begin
          if (sc == CMAX) begin
            state <= IDLE;
            rdy_q <= 1'b1;
            busy  <= 1'b0;
          end else begin
            sc     <= sc + 7'd1;
            we_q   <= 1'b1;
            en_q   <= 1'b1;
            addr_q <= {RMAX, sc + 7'd1};
          end
        end
        CLEAR_ALL: begin
          // we_q low here means the first cycle out of reset: start the sweep
          if (!we_q) begin
            we_q   <= 1'b1;
            en_q   <= 1'b1;
            addr_q <= '0;
            din_q  <= SP;
            sr     <= '0;
            sc     <= '0;
          end else if (sc == CMAX && sr == RMAX) begin
            row   <= '0;
            col   <= '0;
            state <= IDLE;
            rdy_q <= 1'b1;
            busy  <= 1'b0;
          end else if (sc == CMAX) begin
            sc     <= '0;
            sr     <= sr + 6'd1;
            we_q   <= 1'b1;
            en_q   <= 1'b1;
            addr_q <= {sr + 6'd1, 7'd0};
          end else begin
            sc     <= sc + 7'd1;
            we_q   <= 1'b1;
            en_q   <= 1'b1;
            addr_q <= {sr, sc + 7'd1};
          end
        end
        default: state <= CLEAR_ALL;
      endcase
    end
  end
endmodule

// File: tb/tb_tty_writer.sv
// Bench for tty_writer: screen/cursor model predicts every RAM write in order,
// a RAM model answers reads, and literal checks pin key addresses and latencies.
module tb_tty_writer;
  localparam int COLS   = 64;
  localparam int ROWS   = 32;
  localparam int BUDGET = 10000;

  logic clk = 1'b0;
  logic irst_n = 1'b0;
  logic busy;

  tty_writer_if bus();

  tty_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk_data (clk),
    .irst_n   (irst_n),
    .bus      (bus),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:8191];
  logic [7:0]  em  [0:8191];
  logic [20:0] expq [$];
  int          mrow, mcol;
  int          n_vec, n_err;
  logic [12:0] last_wa;
  logic [7:0]  last_wd;

  function automatic logic [12:0] ad(input int r, input int c);
    return 13'(r * 128 + c);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- screen model ----------------
  task automatic push(input int r, input int c, input logic [7:0] d);
    em[ad(r, c)] = d;
    expq.push_back({ad(r, c), d});
  endtask

  task automatic m_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) push(r, c, em[ad(r + 1, c)]);
    for (int c = 0; c < COLS; c++) push(ROWS - 1, c, 8'h20);
  endtask

  task automatic m_newline();
    if (mrow < ROWS - 1) mrow++;
    else m_scroll();
  endtask

  task automatic m_put(input logic [7:0] d);
    push(mrow, mcol, d);
    mcol++;
    if (mcol == COLS) begin
      mcol = 0;
      m_newline();
    end
  endtask

  task automatic m_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) push(r, c, 8'h20);
    mrow = 0;
    mcol = 0;
  endtask

  task automatic m_char(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) m_put(ch);
    else if (ch == 8'h0A) m_newline();
    else if (ch == 8'h0D) mcol = 0;
    else if (ch == 8'h08) begin
      if (mcol > 0) mcol--;
    end
    else if (ch == 8'h0C) m_clear();
`ifdef TTY_TAB_EN
    else if (ch == 8'h09) begin
      do m_put(8'h20); while (mcol % 8 != 0);
    end
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.char_ready && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_within_budget", int'(bus.char_ready), 1);
  endtask

  task automatic send(input logic [7:0] ch);
    int n;
    wait_ready(n);
    bus.char_valid = 1'b1;
    bus.char_data  = ch;
    m_char(ch);
    @(posedge clk); #1;
    bus.char_valid = 1'b0;
  endtask

  task automatic check_ram(input string name);
    int bad = 0;
    for (int i = 0; i < 8192; i++)
      if (mem[i] !== em[i]) bad++;
    chk(name, bad, 0);
  endtask

  initial begin
    int n;
    logic [7:0] discards [$];
    for (int i = 0; i < 8192; i++) begin
      mem[i] = 8'hEE;
      em[i]  = 8'hEE;
    end
    n_vec = 0; n_err = 0; mrow = 0; mcol = 0;
    last_wa = '0; last_wd = '0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.doutb      = 8'h00;

    fork
      // RAM port B: read-first, one-cycle read latency
      forever begin
        @(posedge clk);
        if (bus.enb === 1'b1) begin
          if (bus.web === 1'b1) mem[bus.addrb] <= bus.dinb;
          bus.doutb <= mem[bus.addrb];
        end
      end
      // every RAM write must be the next one the model predicts
      forever begin
        logic [20:0] e;
        @(negedge clk);
        if (bus.web === 1'b1) begin
          n_vec++;
          if (expq.size() == 0) begin
            n_err++;
            $display("FAIL ram_write unexpected addr=%h data=%h", bus.addrb, bus.dinb);
          end else begin
            e = expq.pop_front();
            if ({bus.addrb, bus.dinb} !== e || bus.enb !== 1'b1) begin
              n_err++;
              $display("FAIL ram_write actual addr=%h data=%h enb=%b expected addr=%h data=%h enb=1",
                       bus.addrb, bus.dinb, bus.enb, e[20:8], e[7:0]);
            end
          end
          last_wa = bus.addrb;
          last_wd = bus.dinb;
        end
      end
    join_none

    // reset state and the clear that follows release
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_char_ready", int'(bus.char_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_web", int'(bus.web), 0);
    chk("rst_enb", int'(bus.enb), 0);
    @(posedge clk); #1;
    irst_n = 1'b1;
    m_clear();
    @(posedge clk); #1;
    wait_ready(n);
    chk("clear_after_reset_cycles", n, 2048);

    // first character lands at home
    send(8'h41);
    wait_ready(n);
    chk("put_cycles", n, 2);
    chk("A_addr", int'(last_wa), 'h0000);
    chk("A_data", int'(last_wd), 'h41);

    // backspace overwrite and saturation at col 0
    send(8'h0D);
    send(8'h58); send(8'h08); send(8'h59);
    wait_ready(n);
    chk("XY_addr", int'(last_wa), 'h0000);
    chk("XY_data", int'(last_wd), 'h59);
    send(8'h08); send(8'h08); send(8'h51);
    wait_ready(n);
    chk("bs_sat_addr", int'(last_wa), 'h0000);

    // form feed, then a full row and wrap
    send(8'h0C);
    wait_ready(n);
    chk("ff_cycles", n, 2048);
    repeat (64) send(8'h42);
    send(8'h43);
    wait_ready(n);
    chk("wrap_addr", int'(last_wa), 'h0080);
    chk("wrap_data", int'(last_wd), 'h43);
    check_ram("ram_after_fill");

    // LF on the last row scrolls; cursor column is kept
    repeat (30) send(8'h0A);
    send(8'h0D);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    send(8'h0A);
    wait_ready(n);
    chk("scroll_cycles", n, 4032);
    chk("scroll_row0", int'(mem[13'h0000]), 'h43);
    chk("scroll_row30", int'(mem[13'h0F00]), 'h61);
    chk("scroll_row31", int'(mem[13'h0F80]), 'h20);
    check_ram("ram_after_scroll");
    send(8'h5A);
    wait_ready(n);
    chk("cursor_after_scroll", int'(last_wa), 'h0F85);

    // codes that must be swallowed without a RAM access
    discards = '{8'h00, 8'h1B, 8'h7F, 8'h80, 8'hFF};
`ifndef TTY_TAB_EN
    discards.push_back(8'h09);
`endif
    foreach (discards[i]) begin
      send(discards[i]);
      chk("discard_ready", int'(bus.char_ready), 1);
    end

    // tab from col 3
    send(8'h0D);
    send(8'h61); send(8'h62); send(8'h63);
    send(8'h09);
    send(8'h54);
    wait_ready(n);
`ifdef TTY_TAB_EN
    chk("tab_next_addr", int'(last_wa), 'h0F88);
`else
    chk("tab_next_addr", int'(last_wa), 'h0F83);
`endif

    // column wrap on the last row triggers a scroll
    send(8'h0D);
    repeat (64) send(8'h6B);
    wait_ready(n);
    chk("wrap_scroll_cycles", n, 4034);
    chk("wrap_scroll_row30", int'(mem[13'h0F3F]), 'h6B);
    send(8'h57);
    wait_ready(n);
    chk("wrap_scroll_cursor", int'(last_wa), 'h0F80);

    // reset pulse in the middle of a scroll
    send(8'h0A);
    repeat (99) begin @(posedge clk); #1; end
    irst_n = 1'b0;
    @(negedge clk); #1;
    expq.delete();
    @(posedge clk); #1;
    irst_n = 1'b1;
    @(negedge clk);
    chk("abort_web", int'(bus.web), 0);
    chk("abort_enb", int'(bus.enb), 0);
    chk("abort_ready", int'(bus.char_ready), 0);
    chk("abort_busy", int'(busy), 1);
    m_clear();
    @(posedge clk); #1;
    wait_ready(n);
    chk("abort_clear_cycles", n, 2048);
    send(8'h48);
    wait_ready(n);
    chk("abort_home_addr", int'(last_wa), 'h0000);
    chk("abort_home_data", int'(last_wd), 'h48);
    check_ram("ram_final");
    chk("queue_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
